// File: rtl/dram_page_mode.sv
// dram_page_mode
//   Behavioural model of an asynchronous-strobe page-mode DRAM. The strobes
//   are sampled on i_MCLK. A RAS fall opens a row, and each CAS fall selects
//   a column. CAS-before-RAS starts an internal refresh.
//
//   Optional build macro: REFRESH_CHECK_EN. When it is defined, a refresh
//   watchdog counts cycles between refresh events and sets a sticky
//   o_REFRESH_ERR if more than REFRESH_LIMIT cycles pass with no refresh.
//
//   Parameters
//     DW            data width
//     AW            row/column address width (depth = 2^(2*AW) words)
//     REFRESH_LIMIT max i_MCLK cycles allowed between refresh events
//
//   Ports
//     i_MCLK        clock, rising edge
//     i_RST         synchronous active-high reset
//     i_ADDR        multiplexed row/column address
//     i_DIN         write data
//     i_RAS_n       row strobe, active low
//     i_CAS_n       column strobe, active low
//     i_WR_n        write enable, active low
//     o_DOUT        registered read data
//     o_DOUT_EN     o_DOUT holds valid read data
//     o_REF_ROW     CBR refresh row counter
//     o_REFRESH_ERR sticky refresh-timeout flag
module dram_page_mode #(
  parameter int DW            = 8,
  parameter int AW            = 8,
  parameter int REFRESH_LIMIT = 65535
) (
  input  logic          i_MCLK,
  input  logic          i_RST,
  input  logic [AW-1:0] i_ADDR,
  input  logic [DW-1:0] i_DIN,
  input  logic          i_RAS_n,
  input  logic          i_CAS_n,
  input  logic          i_WR_n,
  output logic [DW-1:0] o_DOUT,
  output logic          o_DOUT_EN,
  output logic [AW-1:0] o_REF_ROW,
  output logic          o_REFRESH_ERR
);

  localparam int DEPTH = 1 << (2 * AW);

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    ROW_OPEN   = 2'd1,
    COL_ACTIVE = 2'd2,
    CBR        = 2'd3
  } state_t;

  state_t          r_state, w_state_nxt;
  logic            r_ras_p, r_cas_p;
  logic [AW-1:0]   r_row, r_col, r_ref_row;
  logic [DW-1:0]   r_dout;
  logic            r_dout_en;
  logic            r_early;    // WR_n was low on the CAS-fall cycle
  logic            r_wr_done;  // this COL_ACTIVE visit has already written
  logic            w_ras_fall, w_cas_fall;
  logic            w_row_ld, w_col_ld, w_cbr_entry;
  logic            w_we;
  logic [2*AW-1:0] w_addr;

  // The declaration initialiser gives zero contents at time 0. Reset does
  // not clear this array.
  logic [DW-1:0]   r_mem [DEPTH] = '{default: '0};

  assign w_ras_fall = !i_RAS_n && r_ras_p;
  assign w_cas_fall = !i_CAS_n && r_cas_p;
  assign w_addr     = {r_col, r_row};

  always_comb begin
    w_state_nxt = r_state;
    w_row_ld    = 1'b0;
    w_col_ld    = 1'b0;
    w_cbr_entry = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_ras_fall) begin
          // CBR needs CAS to be low already. If CAS falls in the same cycle
          // as RAS, the access opens a row, and that CAS fall is not used
          // because the prev register sees CAS as low from then on.
          if (!i_CAS_n && !r_cas_p) begin
            w_state_nxt = CBR;
            w_cbr_entry = 1'b1;
          end else begin
            w_state_nxt = ROW_OPEN;
            w_row_ld    = 1'b1;
          end
        end
      end
      ROW_OPEN: begin
        if (w_cas_fall) begin
          w_state_nxt = COL_ACTIVE;
          w_col_ld    = 1'b1;
        end
      end
      COL_ACTIVE: begin
        if (i_CAS_n) w_state_nxt = ROW_OPEN;
      end
      CBR: ;
      default: w_state_nxt = IDLE;
    endcase
    if (i_RAS_n) begin
      w_state_nxt = IDLE;
      w_col_ld    = 1'b0;
    end
  end

  // Only one write is allowed per COL_ACTIVE visit. A pending early write
  // goes out on the first COL_ACTIVE cycle. Otherwise the write happens on
  // the first cycle that WR_n is low. Reset cancels the write in that cycle.
  assign w_we = (r_state == COL_ACTIVE) && !r_wr_done &&
                (r_early || !i_WR_n) && !i_RST;

  always_ff @(posedge i_MCLK) begin
    if (w_we) r_mem[w_addr] <= i_DIN;
  end

  always_ff @(posedge i_MCLK) begin
    if (i_RST) begin
      r_state   <= IDLE;
      r_ras_p   <= 1'b1;
      r_cas_p   <= 1'b1;
      r_row     <= '0;
      r_col     <= '0;
      r_ref_row <= '0;
      r_dout    <= '0;
      r_dout_en <= 1'b0;
      r_early   <= 1'b0;
      r_wr_done <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_ras_p <= i_RAS_n;
      r_cas_p <= i_CAS_n;
      if (w_row_ld)    r_row     <= i_ADDR;
      if (w_col_ld)    r_col     <= i_ADDR;
      if (w_cbr_entry) r_ref_row <= r_ref_row + AW'(1);
      r_early   <= w_col_ld && !i_WR_n;
      r_wr_done <= w_col_ld ? 1'b0 : (r_wr_done || w_we);
      // Read data is valid only while both strobes stay low and no write
      // has happened in this visit. When it is not valid, o_DOUT keeps its
      // last value.
      if (r_state == COL_ACTIVE && !i_RAS_n && !i_CAS_n && !w_we && !r_wr_done) begin
        r_dout    <= r_mem[w_addr];
        r_dout_en <= 1'b1;
      end else begin
        r_dout_en <= 1'b0;
      end
    end
  end

  assign o_DOUT    = r_dout;
  assign o_DOUT_EN = r_dout_en;
  assign o_REF_ROW = r_ref_row;

`ifdef REFRESH_CHECK_EN
  localparam int             CW  = $clog2(REFRESH_LIMIT + 2);
  localparam logic [CW-1:0]  SAT = CW'(REFRESH_LIMIT + 1);

  logic          r_col_seen;  // a CAS cycle happened since the row opened
  logic [CW-1:0] r_ref_cnt, w_cnt_nxt;
  logic          r_ref_err;
  logic          w_ref_evt;

  // A RAS-only refresh is a row open followed by a RAS rise with no column
  // access in between.
  assign w_ref_evt = w_cbr_entry ||
                     (r_state == ROW_OPEN && i_RAS_n && !r_col_seen);

  always_comb begin
    w_cnt_nxt = r_ref_cnt;
    if (w_ref_evt)              w_cnt_nxt = '0;
    else if (r_ref_cnt != SAT)  w_cnt_nxt = r_ref_cnt + CW'(1);
  end

  always_ff @(posedge i_MCLK) begin
    if (i_RST) begin
      r_col_seen <= 1'b0;
      r_ref_cnt  <= '0;
      r_ref_err  <= 1'b0;
    end else begin
      if (w_row_ld)      r_col_seen <= 1'b0;
      else if (w_col_ld) r_col_seen <= 1'b1;
      r_ref_cnt <= w_cnt_nxt;
      if (w_cnt_nxt == SAT) r_ref_err <= 1'b1;
    end
  end

  assign o_REFRESH_ERR = r_ref_err;
`else
  assign o_REFRESH_ERR = 1'b0;
`endif

endmodule

// File: tb/tb_dram_page_mode.sv
// Directed testbench for dram_page_mode (DW=8, AW=8, REFRESH_LIMIT=100).
// Inputs are driven 1 time unit after each rising edge, and outputs are
// sampled at that same point.
module tb_dram_page_mode;

  logic       clk = 1'b0;
  logic       rst, ras_n, cas_n, wr_n;
  logic [7:0] addr, din;
  logic [7:0] dout, ref_row;
  logic       dout_en, ref_err;

  int errs   = 0;
  int checks = 0;

  always #5 clk = ~clk;

  dram_page_mode #(.DW(8), .AW(8), .REFRESH_LIMIT(100)) dut (
    .i_MCLK(clk), .i_RST(rst), .i_ADDR(addr), .i_DIN(din),
    .i_RAS_n(ras_n), .i_CAS_n(cas_n), .i_WR_n(wr_n),
    .o_DOUT(dout), .o_DOUT_EN(dout_en), .o_REF_ROW(ref_row),
    .o_REFRESH_ERR(ref_err)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Full read cycle. The outputs are captured one cycle after the CAS fall
  // is sampled. Both strobes are left high afterwards.
  task automatic read_word(input logic [7:0] r, input logic [7:0] c,
                           output logic [7:0] d, output logic e);
    addr = r; ras_n = 1'b0; tick();
    addr = c; cas_n = 1'b0; tick();
    tick();
    d = dout; e = dout_en;
    cas_n = 1'b1; ras_n = 1'b1; tick();
  endtask

  task automatic cbr_cycle;
    cas_n = 1'b0; tick();
    ras_n = 1'b0; tick();
    ras_n = 1'b1; cas_n = 1'b1; tick();
  endtask

  task automatic test_reset;
    rst = 1'b1; ras_n = 1'b1; cas_n = 1'b1; wr_n = 1'b1; addr = '0; din = '0;
    tick(); tick();
    rst = 1'b0;
    checks++; if (dout !== 8'h00) begin errs++; $display("FAIL rst_dout got %h want 00", dout); end
    checks++; if (dout_en !== 1'b0) begin errs++; $display("FAIL rst_dout_en got %b want 0", dout_en); end
    checks++; if (ref_row !== 8'h00) begin errs++; $display("FAIL rst_ref_row got %h want 00", ref_row); end
    checks++; if (ref_err !== 1'b0) begin errs++; $display("FAIL rst_ref_err got %b want 0", ref_err); end
  endtask

  task automatic test_early_write;
    logic [7:0] d; logic e;
    addr = 8'h12; ras_n = 1'b0; tick();
    addr = 8'h34; din = 8'hA5; wr_n = 1'b0; cas_n = 1'b0; tick();
    wr_n = 1'b1; tick();
    checks++; if (dout_en !== 1'b0) begin errs++; $display("FAIL ew_en_after_write got %b want 0", dout_en); end
    cas_n = 1'b1; ras_n = 1'b1; tick();
    read_word(8'h12, 8'h34, d, e);
    checks++; if (d !== 8'hA5) begin errs++; $display("FAIL ew_read_dout got %h want a5", d); end
    checks++; if (e !== 1'b1) begin errs++; $display("FAIL ew_read_en got %b want 1", e); end
  endtask

  task automatic test_no_write_row_open;
    logic [7:0] d; logic e;
    addr = 8'h12; ras_n = 1'b0; tick();
    wr_n = 1'b0; din = 8'hEE; tick(); tick();
    wr_n = 1'b1; ras_n = 1'b1; tick();
    read_word(8'h12, 8'h34, d, e);
    checks++; if (d !== 8'hA5) begin errs++; $display("FAIL row_open_nowrite got %h want a5", d); end
  endtask

  task automatic test_page_mode;
    addr = 8'h05; ras_n = 1'b0; tick();
    for (int c = 0; c < 4; c++) begin
      addr = 8'(c); din = 8'(8'h10 + c); wr_n = 1'b0; cas_n = 1'b0; tick();
      wr_n = 1'b1; tick();
      cas_n = 1'b1; tick();
    end
    for (int c = 0; c < 4; c++) begin
      addr = 8'(c); cas_n = 1'b0; tick();
      tick();
      checks++; if (dout !== 8'(8'h10 + c)) begin errs++; $display("FAIL page_dout col %0d got %h want %h", c, dout, 8'(8'h10 + c)); end
      checks++; if (dout_en !== 1'b1) begin errs++; $display("FAIL page_en col %0d got %b want 1", c, dout_en); end
      cas_n = 1'b1; tick();
      if (c == 0) begin
        checks++; if (dout_en !== 1'b0) begin errs++; $display("FAIL page_en_cas_rise got %b want 0", dout_en); end
      end
    end
    ras_n = 1'b1; tick();
  endtask

  task automatic test_late_write;
    logic [7:0] d; logic e;
    addr = 8'h21; ras_n = 1'b0; tick();
    addr = 8'h43; wr_n = 1'b1; cas_n = 1'b0; tick();
    tick();
    checks++; if (dout_en !== 1'b1) begin errs++; $display("FAIL late_pre_en got %b want 1", dout_en); end
    checks++; if (dout !== 8'h00) begin errs++; $display("FAIL late_pre_dout got %h want 00", dout); end
    tick();
    wr_n = 1'b0; din = 8'h3C; tick();
    checks++; if (dout_en !== 1'b0) begin errs++; $display("FAIL late_en_drop got %b want 0", dout_en); end
    wr_n = 1'b1; tick();
    checks++; if (dout_en !== 1'b0) begin errs++; $display("FAIL late_en_stays_low got %b want 0", dout_en); end
    wr_n = 1'b0; din = 8'hFF; tick();   // a second write in the same visit must be ignored
    wr_n = 1'b1; cas_n = 1'b1; ras_n = 1'b1; tick();
    read_word(8'h21, 8'h43, d, e);
    checks++; if (d !== 8'h3C) begin errs++; $display("FAIL late_readback got %h want 3c", d); end
  endtask

  task automatic test_same_cycle_fall;
    logic [7:0] d;
    addr = 8'h12; ras_n = 1'b0; cas_n = 1'b0; tick();
    tick(); tick();
    checks++; if (dout_en !== 1'b0) begin errs++; $display("FAIL same_cycle_no_col got %b want 0", dout_en); end
    cas_n = 1'b1; tick();
    addr = 8'h34; cas_n = 1'b0; tick();
    tick();
    d = dout;
    checks++; if (d !== 8'hA5) begin errs++; $display("FAIL same_cycle_row_latched got %h want a5", d); end
    checks++; if (dout_en !== 1'b1) begin errs++; $display("FAIL same_cycle_en got %b want 1", dout_en); end
    cas_n = 1'b1; ras_n = 1'b1; tick();
  endtask

  task automatic test_cbr;
    logic [7:0] d; logic e;
    rst = 1'b1; tick(); rst = 1'b0;
    wr_n = 1'b0; din = 8'h99;
    for (int i = 0; i < 256; i++) begin
      cbr_cycle();
      if (i == 0) begin
        checks++; if (ref_row !== 8'h01) begin errs++; $display("FAIL cbr_first got %h want 01", ref_row); end
      end
      if (i == 254) begin
        checks++; if (ref_row !== 8'hFF) begin errs++; $display("FAIL cbr_255 got %h want ff", ref_row); end
      end
    end
    wr_n = 1'b1;
    checks++; if (ref_row !== 8'h00) begin errs++; $display("FAIL cbr_wrap got %h want 00", ref_row); end
    read_word(8'h00, 8'h00, d, e);
    checks++; if (d !== 8'h00) begin errs++; $display("FAIL cbr_mem_zero got %h want 00", d); end
    read_word(8'h12, 8'h34, d, e);
    checks++; if (d !== 8'hA5) begin errs++; $display("FAIL cbr_mem_kept got %h want a5", d); end
  endtask

  task automatic test_reset_mid_access;
    logic [7:0] d; logic e;
    rst = 1'b1; tick(); rst = 1'b0;
    cbr_cycle();
    addr = 8'h21; ras_n = 1'b0; tick();
    addr = 8'h43; cas_n = 1'b0; tick();
    tick();
    checks++; if (dout !== 8'h3C) begin errs++; $display("FAIL rmid_pre_dout got %h want 3c", dout); end
    rst = 1'b1; wr_n = 1'b0; din = 8'h77; tick();
    checks++; if (dout !== 8'h00) begin errs++; $display("FAIL rmid_dout got %h want 00", dout); end
    checks++; if (dout_en !== 1'b0) begin errs++; $display("FAIL rmid_en got %b want 0", dout_en); end
    checks++; if (ref_row !== 8'h00) begin errs++; $display("FAIL rmid_ref_row got %h want 00", ref_row); end
    checks++; if (ref_err !== 1'b0) begin errs++; $display("FAIL rmid_ref_err got %b want 0", ref_err); end
    rst = 1'b0; ras_n = 1'b1; cas_n = 1'b1; wr_n = 1'b1; tick();
    read_word(8'h21, 8'h43, d, e);
    checks++; if (d !== 8'h3C) begin errs++; $display("FAIL rmid_no_write got %h want 3c", d); end
  endtask

  task automatic test_refresh;
    rst = 1'b1; tick(); rst = 1'b0;
`ifdef REFRESH_CHECK_EN
    repeat (80) tick();
    addr = 8'h07; ras_n = 1'b0; tick();   // RAS-only refresh
    ras_n = 1'b1; tick();
    repeat (90) tick();
    checks++; if (ref_err !== 1'b0) begin errs++; $display("FAIL ref_ras_only_restart got %b want 0", ref_err); end
    rst = 1'b1; tick(); rst = 1'b0;
    repeat (100) tick();
    checks++; if (ref_err !== 1'b0) begin errs++; $display("FAIL ref_at_limit got %b want 0", ref_err); end
    tick();
    checks++; if (ref_err !== 1'b1) begin errs++; $display("FAIL ref_over_limit got %b want 1", ref_err); end
    cbr_cycle();
    checks++; if (ref_err !== 1'b1) begin errs++; $display("FAIL ref_sticky got %b want 1", ref_err); end
    rst = 1'b1; tick();
    checks++; if (ref_err !== 1'b0) begin errs++; $display("FAIL ref_cleared got %b want 0", ref_err); end
    rst = 1'b0; tick();
`else
    repeat (200) tick();
    checks++; if (ref_err !== 1'b0) begin errs++; $display("FAIL ref_disabled got %b want 0", ref_err); end
`endif
  endtask

  initial begin
    test_reset();
    test_early_write();
    test_no_write_row_open();
    test_page_mode();
    test_late_write();
    test_same_cycle_fall();
    test_cbr();
    test_reset_mid_access();
    test_refresh();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
